// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and FSM encoding for the write-back port arbiter.
// Imported by the interface and the arbiter top.
package wb_port_arbiter_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef enum logic {
      PRI_PIPE = 1'b0,
      PRI_LONG = 1'b1
   } arb_state_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Request/ready handshakes of both write-back sources plus the
// registered register-file write port.
interface wb_port_arbiter_if
   import wb_port_arbiter_pkg::*;
();

   logic              req0_valid;
   logic              req0_ready;
   logic [REG_AW-1:0] req0_rd;
   logic [XLEN-1:0]   req0_data;

   logic              req1_valid;
   logic              req1_ready;
   logic [REG_AW-1:0] req1_rd;
   logic [XLEN-1:0]   req1_data;

   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [XLEN-1:0]   rf_wdata;

   modport master (
      output req0_valid, req0_rd, req0_data,
      output req1_valid, req1_rd, req1_data,
      input  req0_ready, req1_ready,
      input  rf_we, rf_waddr, rf_wdata
   );

   modport slave (
      input  req0_valid, req0_rd, req0_data,
      input  req1_valid, req1_rd, req1_data,
      output req0_ready, req1_ready,
      output rf_we, rf_waddr, rf_wdata
   );

endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: req0 has priority, req1 is forced
// after MAX_STARVE waits. Optional stall counter: WB_ARB_PERF_EN.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int MAX_STARVE = 4,
   parameter int PERF_W     = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   wb_port_arbiter_if.slave   wb
`ifdef WB_ARB_PERF_EN
   ,
   output logic [PERF_W-1:0]  perf_stall_cnt
`endif
);

   localparam int SCW = $clog2(MAX_STARVE + 1);
   localparam logic [SCW-1:0] STARVE_SAT  = SCW'(MAX_STARVE);
   localparam logic [SCW-1:0] STARVE_LAST = SCW'(MAX_STARVE - 1);

   arb_state_e        state_q, state_d;
   logic [SCW-1:0]    starve_q, starve_d;
   logic              rdy0, rdy1;
   logic              xfer0, xfer1;

   logic              rf_we_q;
   logic [REG_AW-1:0] rf_waddr_q;
   logic [XLEN-1:0]   rf_wdata_q;

   // Priority FSM and req1 starvation counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= PRI_PIPE;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   // Ready generation and next-state logic
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      rdy0     = 1'b0;
      rdy1     = 1'b0;
      unique case (state_q)
         PRI_PIPE: begin
            rdy0 = 1'b1;
            rdy1 = !wb.req0_valid;
            if (wb.req1_valid && !rdy1) begin
               if (starve_q == STARVE_LAST)
                  state_d = PRI_LONG;
               if (starve_q != STARVE_SAT)
                  starve_d = starve_q + SCW'(1);
            end else begin
               starve_d = '0;
            end
         end
         PRI_LONG: begin
            rdy1     = 1'b1;
            state_d  = PRI_PIPE;
            starve_d = '0;
         end
         default: begin
            state_d  = PRI_PIPE;
            starve_d = '0;
         end
      endcase
   end

   assign xfer0 = wb.req0_valid && rdy0;
   assign xfer1 = wb.req1_valid && rdy1;

   // Registered write port; writes to x0 are accepted but not enabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else if (xfer0) begin
         rf_we_q    <= (wb.req0_rd != '0);
         rf_waddr_q <= wb.req0_rd;
         rf_wdata_q <= wb.req0_data;
      end else if (xfer1) begin
         rf_we_q    <= (wb.req1_rd != '0);
         rf_waddr_q <= wb.req1_rd;
         rf_wdata_q <= wb.req1_data;
      end else begin
         rf_we_q    <= 1'b0;
      end
   end

   assign wb.req0_ready = rdy0;
   assign wb.req1_ready = rdy1;
   assign wb.rf_we      = rf_we_q;
   assign wb.rf_waddr   = rf_waddr_q;
   assign wb.rf_wdata   = rf_wdata_q;

`ifdef WB_ARB_PERF_EN
   logic [PERF_W-1:0] perf_q;

   // Saturating count of cycles the pipeline is held off
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         perf_q <= '0;
      else if (wb.req0_valid && !rdy0 && (perf_q != '1))
         perf_q <= perf_q + PERF_W'(1);
   end

   assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus
// randomized traffic against a starvation-count reference model.
module tb_wb_port_arbiter;

   localparam int MS = 4;

   logic clk;
   logic rst_n;
   int   tests_run = 0;
   int   fails     = 0;

   wb_port_arbiter_if bus ();

`ifdef WB_ARB_PERF_EN
   logic [15:0] perf;
`endif

   wb_port_arbiter #(.MAX_STARVE(MS), .PERF_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (bus)
`ifdef WB_ARB_PERF_EN
      ,
      .perf_stall_cnt (perf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      bus.req0_valid = 1'b0;
      bus.req0_rd    = '0;
      bus.req0_data  = '0;
      bus.req1_valid = 1'b0;
      bus.req1_rd    = '0;
      bus.req1_data  = '0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req0_rd    = 5'd7;
      bus.req0_data  = 32'hAAAA_0007;
      bus.req1_valid = 1'b1;
      bus.req1_rd    = 5'd9;
      bus.req1_data  = 32'hBBBB_0009;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (bus.rf_we !== 1'b0) begin
         fails++;
         $display("FAIL reset_we: got %b expected 0", bus.rf_we);
      end
      tests_run++;
      if (bus.rf_waddr !== 5'd0) begin
         fails++;
         $display("FAIL reset_waddr: got %0h expected 0", bus.rf_waddr);
      end
      tests_run++;
      if (bus.rf_wdata !== 32'd0) begin
         fails++;
         $display("FAIL reset_wdata: got %0h expected 0", bus.rf_wdata);
      end
`ifdef WB_ARB_PERF_EN
      tests_run++;
      if (perf !== 16'd0) begin
         fails++;
         $display("FAIL reset_perf: got %0d expected 0", perf);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      tests_run++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
         fails++;
         $display("FAIL reset_first_grant: got %b expected 10",
                  {bus.req0_ready, bus.req1_ready});
      end
      @(posedge clk);
      #1;
      tests_run++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !==
          {1'b1, 5'd7, 32'hAAAA_0007}) begin
         fails++;
         $display("FAIL reset_first_write: got %b/%0h/%0h expected 1/7/aaaa0007",
                  bus.rf_we, bus.rf_waddr, bus.rf_wdata);
      end
      @(negedge clk);
      bus.req0_valid = 1'b0;
      #1;
      tests_run++;
      if (bus.req1_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_req1_follow: got %b expected 1", bus.req1_ready);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !==
          {1'b1, 5'd9, 32'hBBBB_0009}) begin
         fails++;
         $display("FAIL reset_req1_write: got %b/%0h/%0h expected 1/9/bbbb0009",
                  bus.rf_we, bus.rf_waddr, bus.rf_wdata);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_req0_only();
      @(negedge clk);
      bus.req0_valid = 1'b1;
      bus.req0_rd    = 5'd5;
      bus.req0_data  = 32'hDEAD_BEEF;
      #1;
      tests_run++;
      if (bus.req0_ready !== 1'b1) begin
         fails++;
         $display("FAIL req0_ready: got %b expected 1", bus.req0_ready);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !==
          {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
         fails++;
         $display("FAIL req0_write: got %b/%0h/%0h expected 1/5/deadbeef",
                  bus.rf_we, bus.rf_waddr, bus.rf_wdata);
      end
      @(negedge clk);
      idle_inputs();
      @(posedge clk);
      #1;
      tests_run++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !==
          {1'b0, 5'd5, 32'hDEAD_BEEF}) begin
         fails++;
         $display("FAIL req0_hold: got %b/%0h/%0h expected 0/5/deadbeef",
                  bus.rf_we, bus.rf_waddr, bus.rf_wdata);
      end
   endtask

   task automatic test_contention();
      logic [4:0]  r0rd, r1rd;
      logic [31:0] r0d, r1d;
      logic        exp1;
      pulse_reset();
      r0rd = 5'd1;
      r0d  = 32'h0000_1000;
      r1rd = 5'd20;
      r1d  = 32'h0000_2000;
      for (int c = 0; c < 10; c++) begin
         if (c != 0) @(negedge clk);
         bus.req0_valid = 1'b1;
         bus.req0_rd    = r0rd;
         bus.req0_data  = r0d;
         bus.req1_valid = 1'b1;
         bus.req1_rd    = r1rd;
         bus.req1_data  = r1d;
         #1;
         exp1 = ((c % 5) == 4);
         tests_run++;
         if ({bus.req0_ready, bus.req1_ready} !== {!exp1, exp1}) begin
            fails++;
            $display("FAIL contention_ready c=%0d: got %b expected %b",
                     c, {bus.req0_ready, bus.req1_ready}, {!exp1, exp1});
         end
         @(posedge clk);
         #1;
         tests_run++;
         if (bus.rf_waddr !== (exp1 ? r1rd : r0rd)) begin
            fails++;
            $display("FAIL contention_winner c=%0d: got %0d expected %0d",
                     c, bus.rf_waddr, exp1 ? r1rd : r0rd);
         end
         if (exp1) begin
            r1rd = r1rd + 5'd1;
            r1d  = r1d + 32'd1;
         end else begin
            r0rd = r0rd + 5'd1;
            r0d  = r0d + 32'd1;
         end
      end
`ifdef WB_ARB_PERF_EN
      tests_run++;
      if (perf !== 16'd2) begin
         fails++;
         $display("FAIL contention_perf: got %0d expected 2", perf);
      end
`endif
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_x0();
      @(negedge clk);
      bus.req1_valid = 1'b1;
      bus.req1_rd    = 5'd0;
      bus.req1_data  = 32'h1234_5678;
      #1;
      tests_run++;
      if (bus.req1_ready !== 1'b1) begin
         fails++;
         $display("FAIL x0_ready: got %b expected 1", bus.req1_ready);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !==
          {1'b0, 5'd0, 32'h1234_5678}) begin
         fails++;
         $display("FAIL x0_write: got %b/%0h/%0h expected 0/0/12345678",
                  bus.rf_we, bus.rf_waddr, bus.rf_wdata);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.req0_valid = 1'b1;
      bus.req0_rd    = 5'd3;
      bus.req0_data  = 32'hC0DE_0003;
      bus.req1_valid = 1'b1;
      bus.req1_rd    = 5'd11;
      bus.req1_data  = 32'hC0DE_0011;
      repeat (MS) @(posedge clk);
      @(negedge clk);
      #1;
      tests_run++;
      if ({bus.req0_ready, bus.req1_ready, bus.rf_we} !== 3'b011) begin
         fails++;
         $display("FAIL midrst_forced: got %b expected 011",
                  {bus.req0_ready, bus.req1_ready, bus.rf_we});
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({bus.req0_ready, bus.req1_ready, bus.rf_we} !== 3'b100) begin
         fails++;
         $display("FAIL midrst_state: got %b expected 100",
                  {bus.req0_ready, bus.req1_ready, bus.rf_we});
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.rf_we !== 1'b0) begin
         fails++;
         $display("FAIL midrst_drop: got %b expected 0", bus.rf_we);
      end
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      bit          p0, p1, w0, w1, e0, e1;
      logic [4:0]  r0rd, r1rd, erd;
      logic [31:0] r0d, r1d, ed;
      logic [4:0]  ma;
      logic [31:0] md;
      int          waited, pr0, pr1;
      int          perf_m;
      pulse_reset();
      p0 = 0; p1 = 0;
      r0rd = '0; r1rd = '0; r0d = '0; r1d = '0;
      ma = '0; md = '0;
      waited = 0;
      perf_m = 0;
      for (int c = 0; c < 600; c++) begin
         pr0 = (c < 300) ? 90 : 45;
         pr1 = (c < 150) ? 80 : 40;
         @(negedge clk);
         if (!p0 && $urandom_range(0, 99) < pr0) begin
            p0   = 1;
            r0rd = 5'($urandom_range(0, 31));
            r0d  = $urandom;
         end
         if (!p1 && $urandom_range(0, 99) < pr1) begin
            p1   = 1;
            r1rd = 5'($urandom_range(0, 31));
            r1d  = $urandom;
         end
         bus.req0_valid = p0;
         bus.req0_rd    = p0 ? r0rd : 5'd0;
         bus.req0_data  = p0 ? r0d : 32'd0;
         bus.req1_valid = p1;
         bus.req1_rd    = p1 ? r1rd : 5'd0;
         bus.req1_data  = p1 ? r1d : 32'd0;
         #1;
         e0 = !(p1 && waited >= MS);
         e1 = (p1 && waited >= MS) || !p0;
         tests_run++;
         if ({bus.req0_ready, bus.req1_ready} !== {e0, e1}) begin
            fails++;
            $display("FAIL rand_ready c=%0d: got %b expected %b",
                     c, {bus.req0_ready, bus.req1_ready}, {e0, e1});
         end
         w0 = p0 && e0;
         w1 = !w0 && p1 && e1;
         if (p0 && !e0 && perf_m != 65535) perf_m++;
         if (p1 && !w1) waited++;
         else waited = 0;
         erd = w0 ? r0rd : r1rd;
         ed  = w0 ? r0d : r1d;
         if (w0 || w1) begin
            ma = erd;
            md = ed;
         end
         @(posedge clk);
         #1;
         tests_run++;
         if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !==
             {(w0 || w1) && (erd != 5'd0), ma, md}) begin
            fails++;
            $display("FAIL rand_write c=%0d: got %b/%0h/%0h expected %b/%0h/%0h",
                     c, bus.rf_we, bus.rf_waddr, bus.rf_wdata,
                     (w0 || w1) && (erd != 5'd0), ma, md);
         end
         if (w0) p0 = 0;
         if (w1) p1 = 0;
      end
`ifdef WB_ARB_PERF_EN
      tests_run++;
      if (perf !== 16'(perf_m)) begin
         fails++;
         $display("FAIL rand_perf: got %0d expected %0d", perf, perf_m);
      end
`endif
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      test_reset();
      test_req0_only();
      test_contention();
      test_x0();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
